// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline definitions: stage state encoding and default bundle widths per inter-stage register.
package pipe_stage_skid_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StBusy  = 2'b01,
        StFull  = 2'b10
    } state_e;

    localparam int unsigned IF_ID_CTRL_WIDTH  = 2;
    localparam int unsigned IF_ID_DATA_WIDTH  = 64;
    localparam int unsigned ID_EX_CTRL_WIDTH  = 16;
    localparam int unsigned ID_EX_DATA_WIDTH  = 160;
    localparam int unsigned EX_MEM_CTRL_WIDTH = 8;
    localparam int unsigned EX_MEM_DATA_WIDTH = 106;
    localparam int unsigned MEM_WB_CTRL_WIDTH = 4;
    localparam int unsigned MEM_WB_DATA_WIDTH = 69;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module pipe_sat_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 clear,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, 2-entry skid buffer, flush and enable.
// Optional performance counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int unsigned CTRL_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 160,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [CTRL_WIDTH-1:0] i_ctrl,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [CTRL_WIDTH-1:0] o_ctrl,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [CNT_WIDTH-1:0]  o_stall_cnt,
    output logic [CNT_WIDTH-1:0]  o_bubble_cnt
);

    state_e                state_q, state_d;
    logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic                  accept, send;

    // Handshake outputs derive only from flops, so o_ready never depends on i_ready.
    assign o_valid = i_enable & (state_q != StEmpty);
    assign o_ready = i_enable & (state_q != StFull);
    assign accept  = i_valid & o_ready;
    assign send    = o_valid & i_ready;
    assign o_ctrl  = o_valid ? main_ctrl_q : '0;
    assign o_data  = main_data_q;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (i_enable && i_flush) begin
            // Data is left untouched; only ctrl must read as a NOP.
            state_d     = StEmpty;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_ctrl_d = i_ctrl;
                        main_data_d = i_data;
                        state_d     = StBusy;
                    end
                end
                StBusy: begin
                    if (accept && send) begin
                        main_ctrl_d = i_ctrl;
                        main_data_d = i_data;
                    end else if (accept) begin
                        skid_ctrl_d = i_ctrl;
                        skid_data_d = i_data;
                        state_d     = StFull;
                    end else if (send) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (send) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        state_d     = StBusy;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= StEmpty;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic perf_clear;

    assign perf_clear = i_enable & i_flush;

    pipe_sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_stall_cnt (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .clear  (perf_clear),
        .inc    (o_valid & ~i_ready),
        .count  (o_stall_cnt)
    );

    pipe_sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_bubble_cnt (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .clear  (perf_clear),
        .inc    (i_enable & ~o_valid),
        .count  (o_bubble_cnt)
    );
`else
    assign o_stall_cnt  = '0;
    assign o_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a 2-deep queue model predicts handshakes, output beats and
// counters; a negedge monitor compares the DUT against it.
module tb_pipe_stage_skid;

    localparam int unsigned CW   = 16;
    localparam int unsigned DW   = 32;
    localparam int unsigned NW   = 4;
    localparam int unsigned CMAX = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_enable = 1'b1;
    logic          i_flush = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_ready = 1'b0;
    logic [CW-1:0] i_ctrl = '0;
    logic [DW-1:0] i_data = '0;
    logic          o_valid, o_ready;
    logic [CW-1:0] o_ctrl;
    logic [DW-1:0] o_data;
    logic [NW-1:0] o_stall_cnt, o_bubble_cnt;

    pipe_stage_skid #(
        .CTRL_WIDTH(CW),
        .DATA_WIDTH(DW),
        .CNT_WIDTH (NW)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_flush     (i_flush),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_ctrl      (i_ctrl),
        .i_data      (i_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_ctrl      (o_ctrl),
        .o_data      (o_data),
        .o_stall_cnt (o_stall_cnt),
        .o_bubble_cnt(o_bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         exp_q[$];
    int unsigned   m_stall = 0;
    int unsigned   m_bubble = 0;
    logic [DW-1:0] last_data = '0;
    bit            took = 1'b0;
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of capacity 2.
    always @(posedge clk) begin
        bit mv, mr, acc, snd;
        took = 1'b0;
        if (!i_reset) begin
            mv   = i_enable && (exp_q.size() > 0);
            mr   = i_enable && (exp_q.size() < 2);
            acc  = mr && i_valid;
            snd  = mv && i_ready;
            took = acc;
            if (i_enable) begin
                if (i_flush) begin
                    exp_q.delete();
                    m_stall  = 0;
                    m_bubble = 0;
                end else begin
                    if (mv && !i_ready && m_stall < CMAX) m_stall++;
                    if (!mv && m_bubble < CMAX) m_bubble++;
                    if (snd) void'(exp_q.pop_front());
                    if (acc) exp_q.push_back('{ctrl: i_ctrl, data: i_data});
                end
            end
        end
    end

    always @(negedge clk) begin
        bit ev;
        ev = i_enable && (exp_q.size() > 0);
        if (exp_q.size() > 0) last_data = exp_q[0].data;
        check("o_valid", o_valid, ev);
        check("o_ready", o_ready, i_enable && (exp_q.size() < 2));
        if (ev) begin
            check("o_ctrl", o_ctrl, exp_q[0].ctrl);
            check("o_data", o_data, exp_q[0].data);
        end else begin
            check("o_ctrl_bubble", o_ctrl, 0);
            check("o_data_hold", o_data, last_data);
        end
`ifdef PIPE_STAGE_PERF_EN
        check("stall_cnt", o_stall_cnt, m_stall);
        check("bubble_cnt", o_bubble_cnt, m_bubble);
`else
        check("stall_cnt_tied", o_stall_cnt, 0);
        check("bubble_cnt_tied", o_bubble_cnt, 0);
`endif
    end

    task automatic drive(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input bit rdy, input bit en, input bit fl);
        i_valid  = v;
        i_ctrl   = c;
        i_data   = d;
        i_ready  = rdy;
        i_enable = en;
        i_flush  = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [CW-1:0] c, input logic [DW-1:0] d, input bit rdy,
                         input int max);
        for (int k = 0; k < max; k++) begin
            drive(1'b1, c, d, rdy, 1'b1, 1'b0);
            if (took) return;
        end
        checks++;
        errors++;
        $display("FAIL offer_timeout: beat %0h not accepted within %0d cycles", c, max);
    endtask

    task automatic do_reset();
        #2;
        i_valid  = 1'b0;
        i_enable = 1'b1;
        i_flush  = 1'b0;
        i_reset  = 1'b1;
        exp_q.delete();
        m_stall   = 0;
        m_bubble  = 0;
        last_data = '0;
        @(posedge clk);
        #1;
        i_reset = 1'b0;
    endtask

    initial begin
        beat_t b;
        bit    v, rdy, en, fl;

        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", o_valid, 0);
        check("reset_ready", o_ready, 1);
        check("reset_ctrl", o_ctrl, 0);
        check("reset_data", o_data, 0);
        i_reset = 1'b0;

        repeat (10) drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        check("idle_valid", o_valid, 0);
        check("idle_ready", o_ready, 1);

        // Full-throughput stream with one cycle of latency.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, CW'(i), DW'(i * 3), 1'b1, 1'b1, 1'b0);
            check("stream_took", took, 1);
            check("stream_ctrl", o_ctrl, i);
            check("stream_ready", o_ready, 1);
        end
        repeat (2) drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);

        // Backpressure fills the skid; third beat must wait upstream.
        offer(16'hA, 32'hA0, 1'b0, 2);
        offer(16'hB, 32'hB0, 1'b0, 2);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'hC, 32'hC0, 1'b0, 1'b1, 1'b0);
            check("full_not_taken", took, 0);
            check("full_ready", o_ready, 0);
        end
        offer(16'hC, 32'hC0, 1'b1, 5);
        repeat (4) drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);

        // Flush while FULL with a beat offered.
        offer(16'hA, 32'hA1, 1'b0, 2);
        offer(16'hB, 32'hB1, 1'b0, 2);
        drive(1'b1, 16'hD, 32'hD1, 1'b0, 1'b1, 1'b1);
        check("flush_valid", o_valid, 0);
        check("flush_ctrl", o_ctrl, 0);
        check("flush_ready", o_ready, 1);
        repeat (3) drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);

        // Freeze while BUSY; flush and offers must be ignored.
        offer(16'h5, 32'h55, 1'b0, 2);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 16'h9, 32'h99, 1'b1, 1'b0, 1'b1);
            check("frozen_valid", o_valid, 0);
            check("frozen_ready", o_ready, 0);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        check("resume_ctrl", o_ctrl, 16'h5);
        repeat (2) drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);

        // Long stall saturates the stall counter; flush clears it.
        offer(16'h7, 32'h77, 1'b0, 2);
        repeat (20) drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
        check("stall_saturated", o_stall_cnt, CMAX);
`else
        check("stall_absent", o_stall_cnt, 0);
`endif
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        check("stall_flushed", o_stall_cnt, 0);

        // Randomized traffic with occasional flush, freeze and mid-run reset.
        b = '{ctrl: CW'($urandom), data: $urandom};
        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 75) do_reset();
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 9) < 7);
            en  = ($urandom_range(0, 9) != 0);
            fl  = ($urandom_range(0, 19) == 0);
            drive(v, b.ctrl, b.data, rdy, en, fl);
            if (took) b = '{ctrl: CW'($urandom), data: $urandom};
        end
        repeat (5) drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        check("drained_valid", o_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
